// File: rtl/crc_tx_pkg.sv
// Shared types and CRC helper for the CRC frame transmitter.
// States run in wire order; crc_next models one serial, non-reflected LFSR step.
package crc_tx_pkg;

    typedef enum logic [2:0] {LOAD, PREAMBLE, LENGTH, PAYLOAD, CRC, IFG} state_e;

    localparam logic [7:0]  CRC8_POLY  = 8'h07;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial step for widths up to 16; bits above w are cleared.
    function automatic logic [15:0] crc_next(input logic [15:0] crc, input logic bit_in,
                                             input logic [15:0] poly, input int unsigned w);
        logic        fb;
        logic [15:0] mask;
        fb   = crc[4'(w - 1)] ^ bit_in;
        mask = 16'((32'h1 << w) - 32'h1);
        return ((crc << 1) ^ (fb ? poly : 16'h0)) & mask;
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// Serial CRC register: reloads on init and advances one bit when en is high.
module crc_serial_lfsr import crc_tx_pkg::*; #(
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= CRC_W'(crc_next(16'(crc_q), bit_in, 16'(CRC_POLY), CRC_W));
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_frame_tx.sv
// Buffers a payload from a byte stream, then sends PREAMBLE, LENGTH, payload and CRC
// MSB first on an NRZ line, followed by an idle-high inter-frame gap.
module crc_frame_tx
    import crc_tx_pkg::state_e, crc_tx_pkg::crc_next, crc_tx_pkg::CRC8_POLY;
#(
    parameter int               BIT_CYCLES = 434,
    parameter int               MAX_BYTES  = 16,
    parameter int               CRC_W      = 8,
    parameter logic [CRC_W-1:0] CRC_POLY   = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT   = '0,
    parameter logic [7:0]       PREAMBLE   = 8'hA5,
    parameter int               IFG_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       test_mode,
    output logic       tx_line,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
);

    localparam int SH_W  = (CRC_W > 8) ? CRC_W : 8;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]       bit_q, bit_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       byte_q, byte_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic             tm_q, tm_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       buf_q [MAX_BYTES];

    logic             hs, cyc_last, bit_last, crc_init, crc_en;
    logic [7:0]       fld_len;
    logic [CRC_W-1:0] crc, crc_final;

    function automatic logic [SH_W-1:0] ld_byte(input logic [7:0] b);
        return SH_W'(b) << (SH_W - 8);
    endfunction

    crc_serial_lfsr #(
        .CRC_W   (CRC_W),
        .CRC_POLY(CRC_POLY),
        .CRC_INIT(CRC_INIT)
    ) u_crc (
        .clk   (clk),
        .rst   (rst),
        .init  (crc_init),
        .en    (crc_en),
        .bit_in(sh_q[SH_W-1]),
        .crc   (crc)
    );

    assign s_ready    = (state_q == crc_tx_pkg::LOAD);
    assign busy       = !s_ready;
    assign tx_line    = (state_q == crc_tx_pkg::LOAD || state_q == crc_tx_pkg::IFG) ? 1'b1 : sh_q[SH_W-1];
    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign hs         = s_valid && s_ready;

    always_comb begin
        case (state_q)
            crc_tx_pkg::CRC: fld_len = 8'(CRC_W);
            crc_tx_pkg::IFG: fld_len = 8'(IFG_BITS);
            default:         fld_len = 8'd8;
        endcase
        cyc_last = (cyc_q == CYC_W'(BIT_CYCLES - 1));
        bit_last = cyc_last && (bit_q == fld_len - 8'd1);
        crc_en   = cyc_last && (state_q == crc_tx_pkg::LENGTH || state_q == crc_tx_pkg::PAYLOAD);
        // Fold in the final payload bit now, since the register only catches up this same clk.
        crc_final = CRC_W'(crc_next(16'(crc), sh_q[SH_W-1], 16'(CRC_POLY), CRC_W)) ^ CRC_W'(tm_q);
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        count_d  = count_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        tm_d     = tm_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        crc_init = 1'b0;

        if (state_q == crc_tx_pkg::LOAD) begin
            if (hs) begin
                count_d = count_q + 8'd1;
                if (s_last || count_q == 8'(MAX_BYTES - 1)) begin
                    state_d  = crc_tx_pkg::PREAMBLE;
                    crc_init = 1'b1;
                    tm_d     = test_mode;
                    sh_d     = ld_byte(PREAMBLE);
                    cyc_d    = '0;
                    bit_d    = '0;
                    ovf_d    = !s_last;
                end
            end
        end else begin
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
            if (cyc_last) begin
                sh_d  = sh_q << 1;
                bit_d = bit_q + 8'd1;
            end
            if (bit_last) begin
                bit_d = '0;
                case (state_q)
                    crc_tx_pkg::PREAMBLE: begin
                        state_d = crc_tx_pkg::LENGTH;
                        sh_d    = ld_byte(count_q);
                    end
                    crc_tx_pkg::LENGTH: begin
                        state_d = crc_tx_pkg::PAYLOAD;
                        sh_d    = ld_byte(buf_q[0]);
                        byte_d  = 8'd1;
                    end
                    crc_tx_pkg::PAYLOAD: begin
                        if (byte_q == count_q) begin
                            state_d = crc_tx_pkg::CRC;
                            sh_d    = SH_W'(crc_final) << (SH_W - CRC_W);
                        end else begin
                            sh_d   = ld_byte(buf_q[IDX_W'(byte_q)]);
                            byte_d = byte_q + 8'd1;
                        end
                    end
                    crc_tx_pkg::CRC: state_d = crc_tx_pkg::IFG;
                    default: begin
                        state_d = crc_tx_pkg::LOAD;
                        done_d  = 1'b1;
                        count_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= crc_tx_pkg::LOAD;
            cyc_q   <= '0;
            bit_q   <= '0;
            count_q <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            tm_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            tm_q    <= tm_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage needs no reset: count_q alone says what is valid.
    always_ff @(posedge clk) begin
        if (hs) buf_q[IDX_W'(count_q)] <= s_data;
    end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx with 4-clk bits, 4-byte buffer and CRC-8 0x07.
module tb_crc_frame_tx;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst, s_valid, s_last, s_ready, test_mode;
    logic       tx_line, busy, frame_done, overflow;
    logic [7:0] s_data;
    logic [7:0] q[$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    crc_frame_tx #(
        .BIT_CYCLES(BC), .MAX_BYTES(4), .CRC_W(8), .CRC_POLY(8'h07),
        .CRC_INIT(8'h00), .PREAMBLE(8'hA5), .IFG_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .test_mode(test_mode), .tx_line(tx_line), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready byte=%h got s_ready=%b exp 1", d, s_ready);
        end
        @(posedge clk);
        #1 s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Samples every clk of a frame that started on the preceding posedge.
    task automatic capture(input string name, input logic [7:0] fr[$], input logic exp_ovf);
        logic [7:0] got;
        logic       s0, unstable, ctl_bad;
        ctl_bad = 1'b0;
        for (int b = 0; b < fr.size(); b++) begin
            got = '0; unstable = 1'b0; s0 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                for (int c = 0; c < BC; c++) begin
                    @(negedge clk);
                    if (b == 0 && i == 0 && c == 0) begin
                        checks++;
                        if (overflow !== exp_ovf) begin
                            errors++;
                            $display("FAIL %s_overflow got %b exp %b", name, overflow, exp_ovf);
                        end
                    end else if (overflow !== 1'b0) ctl_bad = 1'b1;
                    if (busy !== 1'b1 || s_ready !== 1'b0 || frame_done !== 1'b0) ctl_bad = 1'b1;
                    if (c == 0) begin
                        s0  = tx_line;
                        got = {got[6:0], tx_line};
                    end else if (tx_line !== s0) unstable = 1'b1;
                end
            end
            checks++;
            if (got !== fr[b] || unstable) begin
                errors++;
                $display("FAIL %s_byte%0d got %h (unstable=%b) exp %h", name, b, got, unstable, fr[b]);
            end
        end
        for (int c = 0; c < 2 * BC; c++) begin
            @(negedge clk);
            if (tx_line !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0 || overflow !== 1'b0)
                ctl_bad = 1'b1;
        end
        checks++;
        if (ctl_bad) begin
            errors++;
            $display("FAIL %s_ctl got control/idle violation exp busy=1 s_ready=0 ifg high", name);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b ready=%b exp 1 0 1", name, frame_done, busy, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_line, s_ready, busy, frame_done, overflow} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_idle clk%0d got %b exp 11000", i, {tx_line, s_ready, busy, frame_done, overflow});
            end
        end
    endtask

    task automatic test_single();
        send(8'h00, 1'b1);
        q = {8'hA5, 8'h01, 8'h00, 8'h15};
        capture("single", q, 1'b0);
    endtask

    task automatic test_crc_corrupt();
        test_mode = 1'b1;
        send(8'h00, 1'b1);
        test_mode = 1'b0;
        q = {8'hA5, 8'h01, 8'h00, 8'h14};
        capture("testmode", q, 1'b0);
    endtask

    task automatic test_overflow();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h04; s_last = 1'b0;
        @(posedge clk);
        #1 s_data = 8'h05; s_last = 1'b1;
        q = {8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h6C};
        capture("ovf_frame", q, 1'b1);
        @(posedge clk);
        #1 s_valid = 1'b0; s_last = 1'b0;
        q = {8'hA5, 8'h01, 8'h05, 8'h0E};
        capture("ovf_next", q, 1'b0);
    endtask

    task automatic test_reset_mid();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_line, s_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL midreset got line/ready/busy=%b exp 110", {tx_line, s_ready, busy});
        end
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        q = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h27};
        capture("after_reset", q, 1'b0);
    endtask

    task automatic test_noise();
        send(8'h00, 1'b1);
        q = {8'hA5, 8'h01, 8'h00, 8'h15};
        fork
            capture("noise", q, 1'b0);
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk);
                    #1 test_mode = ~test_mode; s_valid = i[0]; s_data = 8'hFF; s_last = 1'b1;
                end
                s_valid = 1'b0; s_last = 1'b0; test_mode = 1'b0;
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_crc_corrupt();
        test_overflow();
        test_reset_mid();
        test_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
